// File: rtl/canvas_write_scheduler_if.sv
// Pen-request and canvas-RAM write-port bundle for canvas_write_scheduler.
interface canvas_write_scheduler_if #(
  parameter int ADDR_W = 10
);
  logic              pen_valid;
  logic [ADDR_W-1:0] pen_addr;
  logic              pen_data;
  logic              pen_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_din;

  modport master (
    output pen_valid, pen_addr, pen_data,
    input  pen_ready, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  pen_valid, pen_addr, pen_data,
    output pen_ready, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/canvas_write_scheduler.sv
// Single write-port owner for the 32x32 canvas RAM: pen writes vs. clear sweeps.
// Optional row-only clear selected by defining CANVAS_ROW_CLEAR_EN.
module canvas_write_scheduler #(
  parameter int   ADDR_W       = 10,
  parameter int   CANVAS_DEPTH = 1024,
  parameter logic CLEAR_VALUE  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  canvas_write_scheduler_if.slave  bus,
  input  logic                     clear_start,
  input  logic [4:0]               clear_row,
  output logic                     busy,
  output logic                     clear_done
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] counter;
  logic [ADDR_W-1:0] sweep_first;
  logic [ADDR_W-1:0] sweep_last;

`ifdef CANVAS_ROW_CLEAR_EN
  logic [4:0] row_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
    end else if (state == IDLE && clear_start) begin
      row_q <= clear_row;
    end
  end

  // First address uses the live row (entry edge); the end bound uses the sampled row.
  assign sweep_first = ADDR_W'({clear_row, 5'd0});
  assign sweep_last  = ADDR_W'({row_q, 5'd31});
`else
  logic unused_clear_row;
  assign unused_clear_row = ^clear_row;
  assign sweep_first      = '0;
  assign sweep_last       = ADDR_W'(CANVAS_DEPTH - 1);
`endif

  assign bus.pen_ready = (state == IDLE) && !clear_start;

  // The entry edge already issues the first sweep write, so busy and mem_we
  // stay high together for exactly the sweep length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= 1'b0;
      busy         <= 1'b0;
      clear_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clear_done <= 1'b0;
          if (clear_start) begin
            state        <= CLEAR;
            busy         <= 1'b1;
            counter      <= sweep_first;
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= sweep_first;
            bus.mem_din  <= CLEAR_VALUE;
          end else if (bus.pen_valid) begin
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= bus.pen_addr;
            bus.mem_din  <= bus.pen_data;
          end else begin
            bus.mem_we   <= 1'b0;
          end
        end
        CLEAR: begin
          if (counter == sweep_last) begin
            state      <= DONE;
            busy       <= 1'b0;
            clear_done <= 1'b1;
            bus.mem_we <= 1'b0;
          end else begin
            counter      <= counter + 1'b1;
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= counter + 1'b1;
            bus.mem_din  <= CLEAR_VALUE;
          end
        end
        DONE: begin
          state      <= IDLE;
          clear_done <= 1'b0;
          bus.mem_we <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          clear_done <= 1'b0;
          bus.mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
